// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble counting.
// One entry deep: each edge either flushes, inserts a bubble, or loads the ID instruction.
module id_ex_reg #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_RegWrite,
  input  logic            id_MemRead,
  input  logic            id_MemWrite,
  input  logic            id_MemtoReg,
  input  logic            id_ALUSrc,
  input  logic            id_Branch,
  input  logic [3:0]      id_ALUOp,
  input  logic            flush,
  output logic [XLEN-1:0] ID_EX_pc,
  output logic [XLEN-1:0] ID_EX_rs1_data,
  output logic [XLEN-1:0] ID_EX_rs2_data,
  output logic [XLEN-1:0] ID_EX_imm,
  output logic [4:0]      ID_EX_rs1,
  output logic [4:0]      ID_EX_rs2,
  output logic [4:0]      ID_EX_rd,
  output logic            ID_EX_RegWrite,
  output logic            ID_EX_MemRead,
  output logic            ID_EX_MemWrite,
  output logic            ID_EX_MemtoReg,
  output logic            ID_EX_ALUSrc,
  output logic            ID_EX_Branch,
  output logic [3:0]      ID_EX_ALUOp,
  output logic            ex_valid,
  output logic            stall,
  output logic [15:0]     bubble_cnt
);

  localparam int unsigned CtrlW = 10;

  typedef enum logic [1:0] {ActLoad, ActStall, ActFlush} action_e;

  // Control bundle order: RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp.
  logic [CtrlW-1:0] id_ctrl;
  logic [CtrlW-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0]  pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic             valid_q, valid_d;
  logic [15:0]      bubble_cnt_q, bubble_cnt_d;
  logic             hazard;
  action_e          action;

  assign id_ctrl = {id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_Branch,
                    id_ALUOp};

  // Load-use: the load in EX targets a register the ID instruction reads; x0 never conflicts.
  assign hazard = valid_q & ctrl_q[8] & (rd_q != 5'd0) & id_valid &
                  ((rd_q == id_rs1) | (rd_q == id_rs2));
  assign stall  = hazard & ~flush;

  always_comb begin
    if (flush) begin
      action = ActFlush;
    end else if (stall) begin
      action = ActStall;
    end else begin
      action = ActLoad;
    end
  end

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    pc_d         = pc_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    bubble_cnt_d = bubble_cnt_q;
    unique case (action)
      ActFlush: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
      ActStall: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        if (bubble_cnt_q != 16'hFFFF) begin
          bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
      end
      default: begin
        valid_d    = id_valid;
        // An invalid slot must never write registers or memory.
        ctrl_d     = id_valid ? id_ctrl : '0;
        pc_d       = id_pc;
        rs1_data_d = id_rs1_data;
        rs2_data_d = id_rs2_data;
        imm_d      = id_imm;
        rs1_d      = id_rs1;
        rs2_d      = id_rs2;
        rd_d       = id_rd;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ID_EX_pc       = pc_q;
  assign ID_EX_rs1_data = rs1_data_q;
  assign ID_EX_rs2_data = rs2_data_q;
  assign ID_EX_imm      = imm_q;
  assign ID_EX_rs1      = rs1_q;
  assign ID_EX_rs2      = rs2_q;
  assign ID_EX_rd       = rd_q;
  assign {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc,
          ID_EX_Branch, ID_EX_ALUOp} = ctrl_q;
  assign bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: directed scenarios plus randomized traffic against a
// cycle-level reference model of the pipeline slot and bubble counter.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [9:0]  id_ctrl;
  logic        flush;

  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_br;
  logic [3:0]  ex_op;
  logic        ex_valid, stall;
  logic [15:0] bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the EX slot should hold after the last edge.
  logic        m_valid;
  logic [9:0]  m_ctrl;
  logic [31:0] m_pc, m_r1d, m_r2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  int          m_bub;
  logic        m_data_ok;

  id_ex_reg #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .id_imm        (id_imm),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_RegWrite   (id_ctrl[9]),
    .id_MemRead    (id_ctrl[8]),
    .id_MemWrite   (id_ctrl[7]),
    .id_MemtoReg   (id_ctrl[6]),
    .id_ALUSrc     (id_ctrl[5]),
    .id_Branch     (id_ctrl[4]),
    .id_ALUOp      (id_ctrl[3:0]),
    .flush         (flush),
    .ID_EX_pc      (ex_pc),
    .ID_EX_rs1_data(ex_rs1_data),
    .ID_EX_rs2_data(ex_rs2_data),
    .ID_EX_imm     (ex_imm),
    .ID_EX_rs1     (ex_rs1),
    .ID_EX_rs2     (ex_rs2),
    .ID_EX_rd      (ex_rd),
    .ID_EX_RegWrite(ex_rw),
    .ID_EX_MemRead (ex_mr),
    .ID_EX_MemWrite(ex_mw),
    .ID_EX_MemtoReg(ex_m2r),
    .ID_EX_ALUSrc  (ex_as),
    .ID_EX_Branch  (ex_br),
    .ID_EX_ALUOp   (ex_op),
    .ex_valid      (ex_valid),
    .stall         (stall),
    .bubble_cnt    (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_stall();
    return m_valid && m_ctrl[8] && (m_rd != 5'd0) && id_valid &&
           ((m_rd == id_rs1) || (m_rd == id_rs2)) && !flush;
  endfunction

  task automatic model_edge(input logic st);
    if (!rst_n) begin
      m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_r1d = '0; m_r2d = '0; m_imm = '0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_bub = 0; m_data_ok = 1'b1;
    end else if (flush || st) begin
      m_valid   = 1'b0;
      m_ctrl    = '0;
      m_data_ok = 1'b0;
      if (!flush && m_bub < 65535) m_bub = m_bub + 1;
    end else begin
      m_valid = id_valid;
      m_ctrl  = id_valid ? id_ctrl : 10'd0;
      m_pc = id_pc; m_r1d = id_rs1_data; m_r2d = id_rs2_data; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_data_ok = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("ex_valid", 64'(ex_valid), 64'(m_valid));
    check("ctrl", 64'({ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_br, ex_op}), 64'(m_ctrl));
    check("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
    if (m_data_ok) begin
      check("idx", 64'({ex_rs1, ex_rs2, ex_rd}), 64'({m_rs1, m_rs2, m_rd}));
      check("pc_imm", {ex_pc, ex_imm}, {m_pc, m_imm});
      check("rs_data", {ex_rs1_data, ex_rs2_data}, {m_r1d, m_r2d});
    end
  endtask

  // Inputs are already driven; check stall, clock one edge, then compare registered state.
  task automatic step();
    logic st;
    #1;
    st = exp_stall();
    check("stall", 64'(stall), 64'(st));
    @(posedge clk);
    model_edge(st);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [9:0] ctrl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = ctrl;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
  endtask

  localparam logic [9:0] CtrlLoad = 10'b11_0100_0000;  // RegWrite, MemRead, MemtoReg
  localparam logic [9:0] CtrlAlu  = 10'b10_0000_0010;  // RegWrite, ALUOp=2

  // EX takes a load to x7, then ID presents a reader of x7 and is held for one bubble.
  task automatic load_use_pair();
    drive_id(1'b1, 5'd1, 5'd1, 5'd7, CtrlLoad);
    step();
    drive_id(1'b1, 5'd3, 5'd7, 5'd9, CtrlAlu);
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    drive_id(1'b1, 5'd7, 5'd7, 5'd7, CtrlLoad);
    step();
    step();
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_cnt", 64'(bubble_cnt), 64'd0);
    check("rst_pc", 64'(ex_pc), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);

    // Plain load
    rst_n = 1'b1;
    drive_id(1'b1, 5'd1, 5'd2, 5'd5, CtrlAlu);
    step();
    check("plain_rd", 64'(ex_rd), 64'd5);
    check("plain_rw", 64'(ex_rw), 64'd1);
    check("plain_op", 64'(ex_op), 64'd2);
    check("plain_valid", 64'(ex_valid), 64'd1);

    // Load-use: one bubble then the held instruction loads
    drive_id(1'b1, 5'd1, 5'd1, 5'd7, CtrlLoad);
    step();
    drive_id(1'b1, 5'd3, 5'd7, 5'd9, CtrlAlu);
    #1 check("lu_stall", 64'(stall), 64'd1);
    step();
    check("lu_bubble_valid", 64'(ex_valid), 64'd0);
    check("lu_bubble_mr", 64'(ex_mr), 64'd0);
    check("lu_cnt", 64'(bubble_cnt), 64'd1);
    #1 check("lu_stall_clear", 64'(stall), 64'd0);
    step();
    check("lu_loaded_rs2", 64'(ex_rs2), 64'd7);
    check("lu_loaded_valid", 64'(ex_valid), 64'd1);

    // x0 never stalls
    drive_id(1'b1, 5'd1, 5'd1, 5'd0, CtrlLoad);
    step();
    drive_id(1'b1, 5'd0, 5'd0, 5'd4, CtrlAlu);
    #1 check("x0_stall", 64'(stall), 64'd0);
    step();
    check("x0_cnt", 64'(bubble_cnt), 64'd1);
    check("x0_valid", 64'(ex_valid), 64'd1);

    // Flush with hazard present
    drive_id(1'b1, 5'd1, 5'd1, 5'd7, CtrlLoad);
    step();
    drive_id(1'b1, 5'd7, 5'd2, 5'd9, CtrlAlu);
    flush = 1'b1;
    #1 check("fl_stall", 64'(stall), 64'd0);
    step();
    flush = 1'b0;
    check("fl_valid", 64'(ex_valid), 64'd0);
    check("fl_ctrl", 64'({ex_rw, ex_mr, ex_op}), 64'd0);
    check("fl_cnt", 64'(bubble_cnt), 64'd1);

    // Reset while stalled
    drive_id(1'b1, 5'd1, 5'd1, 5'd7, CtrlLoad);
    step();
    drive_id(1'b1, 5'd7, 5'd7, 5'd9, CtrlAlu);
    #1 check("rm_stall_pre", 64'(stall), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rm_valid", 64'(ex_valid), 64'd0);
    check("rm_cnt", 64'(bubble_cnt), 64'd0);
    check("rm_rd", 64'(ex_rd), 64'd0);
    #1 check("rm_stall", 64'(stall), 64'd0);
    step();
    check("rm_post_rd", 64'(ex_rd), 64'd9);

    // Saturation: preset the counter near the top, then keep hazarding
    force dut.bubble_cnt_q = 16'hFFFD;
    #1 release dut.bubble_cnt_q;
    m_bub = 65533;
    for (int i = 0; i < 3; i++) load_use_pair();
    check("sat_cnt", 64'(bubble_cnt), 64'hFFFF);

    // Randomized traffic; a stalled ID instruction is held like the real pipeline would
    for (int i = 0; i < 600; i++) begin
      logic held;
      held  = exp_stall();
      rst_n = ($urandom_range(0, 79) != 0);
      flush = ($urandom_range(0, 9) == 0);
      if (!held || $urandom_range(0, 7) == 0) begin
        drive_id(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 10'($urandom));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
